// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M multiply/divide encodings and constants
package riscv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam logic [31:0] MD_DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the Execute stage
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MulDivStartE,
    input  logic [2:0]       funct3E,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             StallMD,
    output logic             MulDivDoneE,
    output logic [WIDTH-1:0] MulDivResultE
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        r_state, w_next;
    md_op_t           r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_b, r_hi, r_lo, r_srca, r_result;
    logic             r_sign_a, r_sign_b, r_div0, r_ovf;

    md_op_t           w_op;
    logic             w_start, w_signed_a, w_signed_b, w_neg_a, w_neg_b, w_div_op;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_mul_sum, w_shift;
    logic [WIDTH-1:0] w_diff, w_hi_nxt, w_lo_nxt;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0] w_quot, w_rem, w_fix_result;

    assign w_op       = md_op_t'(funct3E);
    assign w_start    = (r_state == IDLE) && MulDivStartE && !FlushE;
    assign w_signed_a = (w_op == MD_MULH) || (w_op == MD_MULHSU) || (w_op == MD_DIV) || (w_op == MD_REM);
    assign w_signed_b = (w_op == MD_MULH) || (w_op == MD_DIV) || (w_op == MD_REM);
    assign w_div_op   = funct3E[2];
    assign w_neg_a    = w_signed_a && SrcAE[WIDTH-1];
    assign w_neg_b    = w_signed_b && SrcBE[WIDTH-1];
    assign w_mag_a    = w_neg_a ? -SrcAE : SrcAE;
    assign w_mag_b    = w_neg_b ? -SrcBE : SrcBE;

    // One iteration: multiply shifts {hi,lo} right, divide shifts the dividend out of lo into hi.
    assign w_mul_sum = {1'b0, r_hi} + {1'b0, r_b};
    assign w_shift   = {r_hi, r_lo[WIDTH-1]};
    assign w_diff    = w_shift[WIDTH-1:0] - r_b;

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) begin
            if (w_shift >= {1'b0, r_b}) begin
                w_hi_nxt = w_diff;
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else if (r_lo[0]) begin
            w_hi_nxt = w_mul_sum[WIDTH:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end else begin
            w_hi_nxt = {1'b0, r_hi[WIDTH-1:1]};
            w_lo_nxt = {r_hi[0], r_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_s = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
        w_quot   = (r_sign_a ^ r_sign_b) ? -r_lo : r_lo;
        w_rem    = r_sign_a ? -r_hi : r_hi;
        if (r_div0) begin
            w_quot = WIDTH'(MD_DIV0_Q);
            w_rem  = r_srca;
        end else if (r_ovf) begin
            w_quot = WIDTH'(MD_INT_MIN);
            w_rem  = '0;
        end
        case (r_op)
            MD_MUL:                      w_fix_result = w_prod_s[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_fix_result = w_prod_s[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:             w_fix_result = w_quot;
            default:                     w_fix_result = w_rem;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = BUSY;
            BUSY:    if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
        if (FlushE) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_op     <= MD_MUL;
            r_cnt    <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_srca   <= '0;
            r_result <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (FlushE) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: if (w_start) begin
                        r_op     <= w_op;
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_lo     <= w_mag_a;
                        r_b      <= w_mag_b;
                        r_srca   <= SrcAE;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_div0   <= w_div_op && (SrcBE == '0);
                        r_ovf    <= w_signed_b && w_div_op && (SrcAE == WIDTH'(MD_INT_MIN)) && (SrcBE == '1);
                    end
                    BUSY: begin
                        r_cnt <= r_cnt + 1'b1;
                        r_hi  <= w_hi_nxt;
                        r_lo  <= w_lo_nxt;
                    end
                    FIX:     r_result <= w_fix_result;
                    default: ;
                endcase
            end
        end
    end

    // Gated by rst so the stall drops the instant reset is asserted, even with a start pending.
    assign StallMD       = rst && (w_start || (r_state == BUSY) || (r_state == FIX));
    assign MulDivDoneE   = (r_state == DONE);
    assign MulDivResultE = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        MulDivStartE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        StallMD;
    logic        MulDivDoneE;
    logic [31:0] MulDivResultE;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .MulDivStartE  (MulDivStartE),
        .funct3E       (funct3E),
        .SrcAE         (SrcAE),
        .SrcBE         (SrcBE),
        .FlushE        (FlushE),
        .StallMD       (StallMD),
        .MulDivDoneE   (MulDivDoneE),
        .MulDivResultE (MulDivResultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts an op at a falling edge (cycle 0), scrambles the operand inputs during BUSY,
    // and reports the result, the cycle of the done pulse and any stall-shape errors.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a_in, input logic [31:0] b_in,
                         output logic [31:0] r, output int lat, output int stall_bad);
        r = 32'h0;
        lat = -1;
        stall_bad = 0;
        @(negedge clk);
        MulDivStartE = 1'b1;
        funct3E = op;
        SrcAE = a_in;
        SrcBE = b_in;
        FlushE = 1'b0;
        #1;
        if (!StallMD) stall_bad++;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 2) begin
                funct3E = ~op;
                SrcAE = ~a_in;
                SrcBE = 32'h0000_1234;
            end
            #1;
            if (MulDivDoneE) begin
                lat = n;
                r = MulDivResultE;
                if (StallMD) stall_bad++;
                MulDivStartE = 1'b0;
                break;
            end
            if (!StallMD) stall_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        MulDivStartE = 1'b0;
        funct3E = 3'b000;
        SrcAE = 32'h0;
        SrcBE = 32'h0;
        FlushE = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (StallMD !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", StallMD); end
        total++; if (MulDivDoneE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", MulDivDoneE); end
        total++; if (MulDivResultE !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", MulDivResultE); end
        MulDivStartE = 1'b1;
        #1;
        total++; if (StallMD !== 1'b0) begin bad++; $display("FAIL reset_stall_with_start got=%b want=0", StallMD); end
        MulDivStartE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_table(input string name, input logic [2:0] ops [], input logic [31:0] av [],
                             input logic [31:0] bv [], input logic [31:0] ev []);
        logic [31:0] r;
        int lat, sb;
        for (int i = 0; i < ops.size(); i++) begin
            do_op(ops[i], av[i], bv[i], r, lat, sb);
            total++; if (r !== ev[i]) begin bad++; $display("FAIL %s_result[%0d] got=%h want=%h", name, i, r, ev[i]); end
            total++; if (lat != 34) begin bad++; $display("FAIL %s_latency[%0d] got=%0d want=34", name, i, lat); end
            total++; if (sb != 0) begin bad++; $display("FAIL %s_stall[%0d] got=%0d_bad_cycles want=0", name, i, sb); end
        end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000, 3'b001};
        logic [31:0] av  [] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
        logic [31:0] bv  [] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h10, 32'h80000000};
        logic [31:0] ev  [] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h23456780, 32'h40000000};
        run_table("mul", ops, av, bv, ev);
    endtask

    task automatic test_div();
        logic [2:0]  ops [] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] av  [] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100};
        logic [31:0] bv  [] = '{32'd3, 32'd3, 32'd7, 32'd7};
        logic [31:0] ev  [] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2};
        run_table("div", ops, av, bv, ev);
    endtask

    task automatic test_div_special();
        logic [2:0]  ops [] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] av  [] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd7, 32'hFFFFFFF9};
        logic [31:0] bv  [] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] ev  [] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9};
        run_table("divspec", ops, av, bv, ev);
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat, sb, early_done, done_cyc;
        do_op(3'b000, 32'd3, 32'd5, r, lat, sb);
        total++; if (r !== 32'd15) begin bad++; $display("FAIL flush_pre_result got=%h want=0000000f", r); end
        early_done = 0;
        done_cyc = -1;
        @(negedge clk);
        MulDivStartE = 1'b1;
        funct3E = 3'b100;
        SrcAE = 32'd100;
        SrcBE = 32'd7;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 10) FlushE = 1'b1;
            if (c == 11) begin FlushE = 1'b0; MulDivStartE = 1'b0; end
            if (c == 12) begin MulDivStartE = 1'b1; funct3E = 3'b000; SrcAE = 32'd9; SrcBE = 32'd9; end
            #1;
            if (c == 11) begin
                total++; if (StallMD !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", StallMD); end
                total++; if (MulDivResultE !== 32'd15) begin bad++; $display("FAIL flush_result_hold got=%h want=0000000f", MulDivResultE); end
            end
            if (MulDivDoneE) begin
                if (c < 46) early_done++;
                done_cyc = c;
                r = MulDivResultE;
                MulDivStartE = 1'b0;
                break;
            end
        end
        total++; if (early_done != 0) begin bad++; $display("FAIL flush_no_done got=%0d want=0", early_done); end
        total++; if (done_cyc != 46) begin bad++; $display("FAIL flush_restart_cycle got=%0d want=46", done_cyc); end
        total++; if (r !== 32'd81) begin bad++; $display("FAIL flush_restart_result got=%h want=00000051", r); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        int lat, sb;
        @(negedge clk);
        MulDivStartE = 1'b1;
        funct3E = 3'b000;
        SrcAE = 32'd6;
        SrcBE = 32'd7;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (StallMD !== 1'b0) begin bad++; $display("FAIL areset_stall got=%b want=0", StallMD); end
        total++; if (MulDivDoneE !== 1'b0) begin bad++; $display("FAIL areset_done got=%b want=0", MulDivDoneE); end
        total++; if (MulDivResultE !== 32'h0) begin bad++; $display("FAIL areset_result got=%h want=00000000", MulDivResultE); end
        @(negedge clk);
        rst = 1'b1;
        MulDivStartE = 1'b0;
        do_op(3'b000, 32'd6, 32'd7, r, lat, sb);
        total++; if (r !== 32'd42) begin bad++; $display("FAIL areset_after_result got=%h want=0000002a", r); end
        total++; if (lat != 34) begin bad++; $display("FAIL areset_after_latency got=%0d want=34", lat); end
        total++; if (sb != 0) begin bad++; $display("FAIL areset_after_stall got=%0d want=0", sb); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
